// File: rtl/bin_lookup_sequencer.sv
// bin_lookup_sequencer: binary search of the sorted BIN ROM for one key,
// then hand the index/found flags to getBankName, wait for its answer (or
// give up after NAME_TIMEOUT cycles) and present the latched bank name to
// the UI on a valid/ack handshake.
module bin_lookup_sequencer #(
  parameter int DEPTH        = 2638,
  parameter int ADDR_W       = 12,
  parameter int KEY_W        = 20,
  parameter int NAME_W       = 100,
  parameter int NAME_TIMEOUT = 15
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              start,
  input  logic [KEY_W-1:0]  bin_in,
  output logic              busy,
  output logic [ADDR_W-1:0] bin_rom_addr,
  input  logic [KEY_W-1:0]  bin_rom_q,
  output logic [ADDR_W-1:0] found_index,
  output logic              binary_search_done,
  output logic              binary_search_found,
  input  logic [NAME_W-1:0] bank_name_in,
  input  logic              bank_name_search_done,
  output logic [NAME_W-1:0] result_name,
  output logic              result_found,
  output logic              result_timeout,
  output logic              result_valid,
  input  logic              result_ack
);

  localparam int TMO_W = $clog2(NAME_TIMEOUT + 1);
  localparam logic [ADDR_W:0] HI_INIT = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WAIT, S_CMP, S_NAME_WAIT, S_RESULT
  } state_t;

  state_t              state_q, state_d;
  logic [KEY_W-1:0]    key_q, key_d;
  // lo/hi carry one extra bit so lo=DEPTH and hi=mid-1 never wrap
  logic [ADDR_W:0]     lo_q, lo_d, hi_q, hi_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   fidx_q, fidx_d;
  logic                found_q, found_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [NAME_W-1:0]   rname_q, rname_d;
  logic                rfound_q, rfound_d;
  logic                rtmo_q, rtmo_d;

  logic [ADDR_W:0]     mid_sum, mid_ext, lo_n, hi_n;
  logic [ADDR_W-1:0]   mid_w;
  logic                miss;

  // state and datapath registers; reset aborts any lookup in flight
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      key_q    <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      addr_q   <= '0;
      fidx_q   <= '0;
      found_q  <= 1'b0;
      tmo_q    <= '0;
      rname_q  <= '0;
      rfound_q <= 1'b0;
      rtmo_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      addr_q   <= addr_d;
      fidx_q   <= fidx_d;
      found_q  <= found_d;
      tmo_q    <= tmo_d;
      rname_q  <= rname_d;
      rfound_q <= rfound_d;
      rtmo_q   <= rtmo_d;
    end
  end

  // next-state: one probe is ADDR -> WAIT -> CMP, then name handshake
  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    addr_d   = addr_q;
    fidx_d   = fidx_q;
    found_d  = found_q;
    tmo_d    = tmo_q;
    rname_d  = rname_q;
    rfound_d = rfound_q;
    rtmo_d   = rtmo_q;
    mid_sum  = lo_q + hi_q;
    mid_w    = ADDR_W'(mid_sum >> 1);
    mid_ext  = {1'b0, addr_q};
    lo_n     = lo_q;
    hi_n     = hi_q;
    miss     = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        key_d    = bin_in;
        lo_d     = '0;
        hi_d     = HI_INIT;
        fidx_d   = '0;
        found_d  = 1'b0;
        rname_d  = '0;
        rfound_d = 1'b0;
        rtmo_d   = 1'b0;
        state_d  = S_ADDR;
      end
      S_ADDR: begin
        addr_d  = mid_w;
        state_d = S_WAIT;
      end
      S_WAIT: state_d = S_CMP;
      S_CMP: begin
        tmo_d = '0;
        if (bin_rom_q == key_q) begin
          fidx_d  = addr_q;
          found_d = 1'b1;
          state_d = S_NAME_WAIT;
        end else begin
          if (bin_rom_q < key_q)  lo_n = mid_ext + (ADDR_W+1)'(1);
          else if (addr_q == '0)  miss = 1'b1;
          else                    hi_n = mid_ext - (ADDR_W+1)'(1);
          if (miss || (lo_n > hi_n)) begin
            fidx_d  = '0;
            found_d = 1'b0;
            state_d = S_NAME_WAIT;
          end else begin
            lo_d    = lo_n;
            hi_d    = hi_n;
            state_d = S_ADDR;
          end
        end
      end
      S_NAME_WAIT: begin
        if (bank_name_search_done) begin
          rname_d  = bank_name_in;
          rfound_d = found_q;
          rtmo_d   = 1'b0;
          state_d  = S_RESULT;
        end else if (tmo_q == TMO_W'(NAME_TIMEOUT)) begin
          rname_d  = '0;
          rfound_d = 1'b0;
          rtmo_d   = 1'b1;
          state_d  = S_RESULT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_RESULT: if (result_ack) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign busy                = (state_q != S_IDLE);
  assign bin_rom_addr        = addr_q;
  assign found_index         = fidx_q;
  assign binary_search_done  = (state_q == S_NAME_WAIT);
  assign binary_search_found = found_q;
  assign result_name         = rname_q;
  assign result_found        = rfound_q;
  assign result_timeout      = rtmo_q;
  assign result_valid        = (state_q == S_RESULT);

endmodule

// File: doc/bin_lookup_sequencer.md
# bin_lookup_sequencer

Sequences one complete card-BIN lookup. It binary-searches the sorted BIN ROM for a 20-bit key, then drives `getBankName` with the index, done and found signals, and waits for that stage's handshake. It latches the 100-bit bank name and presents it to the display/UI logic on a valid/ack handshake. The block sits between the keypad/entry front end and the bank-name datapath, and it owns the BIN ROM address port.

## Interface
- `DEPTH`, 2638: number of sorted entries in the BIN ROM.
- `ADDR_W`, 12: ROM address / index width.
- `KEY_W`, 20: BIN key width (6 decimal digits, max 999999).
- `NAME_W`, 100: bank-name width.
- `NAME_TIMEOUT`, 15: maximum cycles to wait for `bank_name_search_done`.

Ports:
- `CLOCK_50`  in  1  sole clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `bin_in`  in  KEY_W  key; captured on the accepted `start`.
- `busy`  out  1  high in every state except IDLE.
- `bin_rom_addr`  out  ADDR_W  registered ROM address.
- `bin_rom_q`  in  KEY_W  ROM data; valid 1 cycle after the address.
- `found_index`  out  ADDR_W  to `getBankName`.
- `binary_search_done`  out  1  level signal, held until the name handshake completes.
- `binary_search_found`  out  1  valid while `binary_search_done` is high.
- `bank_name_in`  in  NAME_W  from `getBankName.bank_name`.
- `bank_name_search_done`  in  1  from `getBankName`.
- `result_name`  out  NAME_W  latched name.
- `result_found`  out  1  key was present in the ROM.
- `result_timeout`  out  1  name stage never answered.
- `result_valid`  out  1  result available; held until ack.
- `result_ack`  in  1  consumer acknowledge.

## Operation
States: IDLE, ADDR, WAIT, CMP, NAME_WAIT, RESULT.
- **IDLE:** on `start`, capture the key. Set `lo`=0 and `hi`=DEPTH-1; `lo`/`hi` are ADDR_W+1 bits and signed-safe. Go to ADDR.
- **ADDR:** `mid`=(`lo`+`hi`)>>1 using an ADDR_W+1-bit sum. Register `bin_rom_addr`=`mid`. Go to WAIT.
- **WAIT:** one cycle for ROM latency. Go to CMP.
- **CMP:** compare `bin_rom_q` with the key.
  - Equal: `found_index`=`mid`, found=1, go to NAME_WAIT.
  - q < key: `lo`=`mid`+1.
  - q > key: if `mid`==0, not found; else `hi`=`mid`-1.
  - After an update, if `lo` > `hi`: found=0, `found_index`=0, go to NAME_WAIT. Otherwise go to ADDR.
- **NAME_WAIT:** hold `binary_search_done`=1 and hold `binary_search_found`.
  - On the first cycle `bank_name_search_done`=1: latch `result_name`←`bank_name_in`, set `result_found`, `result_timeout`=0, go to RESULT.
  - If `NAME_TIMEOUT` cycles elapse first: `result_name`=0, `result_found`=0, `result_timeout`=1, go to RESULT.
- **RESULT:** `binary_search_done`=0 and `result_valid`=1. On `result_ack`, go to IDLE; `result_valid` drops on that edge.

Other rules:
- `start` outside IDLE is ignored and is not queued.
- `start` and `result_ack` in the same cycle while in RESULT: return to IDLE only. The `start` is not accepted.
- Result outputs hold their values until the next accepted `start`, which clears `result_name`, `result_found` and `result_timeout` to 0.
- The probe count never exceeds ceil(log2(DEPTH)) = 12.

## Timing
- **Reset values:** all outputs are 0 and the state is IDLE. Reset mid-search or mid-handshake aborts immediately; `binary_search_done` falls with reset, so `getBankName` clears.
- **Probe cost:** 3 cycles (ADDR, WAIT, CMP).
- **Search latency:** from the `start` edge to entry into NAME_WAIT is 3·p cycles, where p is the number of probes (1..12).
- **Name stage:** `getBankName` answers 3 cycles after `binary_search_done` rises (two pipeline registers plus the output register). The result is therefore latched on the 3rd NAME_WAIT cycle, and `result_valid` rises on the next cycle.
- **Best case:** a hit on the first probe (`mid`=1318) gives `result_valid` 3+3+1 = 7 cycles after `start`.
- **Worst case:** 36+3+1 = 40 cycles.
- `binary_search_done` is low for at least one cycle between lookups, because of RESULT, so the `getBankName` pipeline always drains.

## Test plan
- ROM model with entry k = 400000+10·k and 1-cycle read. Key 413180 → hit at index 1318 on probe 1; `result_valid` at start+7; `result_found`=1; `result_name` equals the name model output for index 1318.
- Key 400000 → index 0, found=1, p ≤ 12. Key 426370 → index 2637, found=1. No `bin_rom_addr` outside 0..2637.
- Key 400005 and key 0 → `found_index`=0 and `result_found`=0. `result_name` equals the "BANK NAME NOT FOUND" constant from the name stage. `mid`=0 path has no underflow.
- Name-stage stub that never raises `bank_name_search_done` → `result_timeout`=1, `result_name`=0, `result_valid` at NAME_WAIT entry + 15 + 1.
- Pulse `start` with key 999999 during a search and during RESULT → ignored; the original result is unchanged. After `result_ack`, a new `start` is accepted the next cycle.
- Assert `resetn` low during WAIT and again during NAME_WAIT → `busy`, `binary_search_done` and `result_valid` go to 0 asynchronously. A following lookup of 413180 completes normally.
